// File: rtl/uart_rx_byte_pkg.sv
// Shared types and constants for the UART receive path.
// Contents:
//   uart_rx_state_e   - receiver FSM state encoding
//   UART_CLKS_PER_BIT - default clocks per bit (50 MHz / 115200), shared with TX
//   UART_DATA_BITS    - payload bits per frame (8N1)
//   half_bit_cnt()    - mid-bit sample point for a given bit period
package uart_rx_byte_pkg;

    localparam int unsigned UART_CLKS_PER_BIT = 434;
    localparam int unsigned UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_rx_state_e;

    // Mid-bit offset, rounded down.
    function automatic int unsigned half_bit_cnt(input int unsigned clks_per_bit);
        return (clks_per_bit - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_byte_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Ports:
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset; both flops load RESET_VAL
//   d_i    - asynchronous input
//   q_o    - synchronised output (two clk_i edges of latency)
module uart_rx_byte_sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Metastability chain; only sync_q is used downstream.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronises the raw line, qualifies the start bit at
// mid-bit, samples each data bit at its centre and checks the stop bit.
// Ports:
//   ipClk        - system clock
//   ipnReset     - asynchronous active-low reset
//   ipRx         - raw serial line, idle high, asynchronous
//   opData       - last good byte (LSB received first), held until the next one
//   opValid      - one-cycle strobe, opData is new in that cycle
//   opFrameError - one-cycle strobe, stop bit sampled low
//   opBusy       - high whenever the receiver is not idle
module uart_rx_byte
    import uart_rx_byte_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       ipClk,
    input  logic       ipnReset,
    input  logic       ipRx,
    output logic [7:0] opData,
    output logic       opValid,
    output logic       opFrameError,
    output logic       opBusy
);

    if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
        $error("uart_rx_byte: CLKS_PER_BIT must be at least 4");
    end

    localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned HALF    = half_bit_cnt(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    // START is entered one edge after rx_s falls, so the start sample is
    // taken on the edge where the counter would advance to HALF.
    localparam logic [CNT_W-1:0] START_CNT = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(UART_DATA_BITS - 1);

    logic rx_s;

    uart_rx_byte_sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_i  (ipClk),
        .rst_ni (ipnReset),
        .d_i    (ipRx),
        .q_o    (rx_s)
    );

    uart_rx_state_e   state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    // FSM and datapath state register.
    always_ff @(posedge ipClk or negedge ipnReset) begin
        if (!ipnReset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // Next-state, counters and strobe decode.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d   = ST_START;
                    bit_cnt_d = '0;
                end
            end
            ST_START: begin
                if (bit_cnt_q == START_CNT) begin
                    bit_cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_cnt_q == LAST_CNT) begin
                    bit_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_cnt_q == LAST_CNT) begin
                    bit_cnt_d = '0;
                    // Leaving at mid-stop-bit lets a start bit that follows
                    // a single stop bit be caught.
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            ST_BREAK: begin
                // Hold off until the line is released so a long low is not
                // taken as a stream of start bits.
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output register.
    always_ff @(posedge ipClk or negedge ipnReset) begin
        if (!ipnReset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign opData       = data_q;
    assign opValid      = valid_q;
    assign opFrameError = ferr_q;
    assign opBusy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at CLKS_PER_BIT=16 (H=7).
module tb_uart_rx_byte;

    localparam int unsigned CPB   = 16;
    localparam int unsigned BIT_T = 1600;   // clock period is 100 time units
    localparam int unsigned BIT_F = 1648;   // +3 % bit time
    localparam int unsigned BIT_S = 1552;   // -3 % bit time
    localparam int unsigned STOP_EDGE = 2 + 7 + 9 * CPB;   // 153

    logic       ipClk = 1'b0;
    logic       ipnReset;
    logic       ipRx;
    logic [7:0] opData;
    logic       opValid;
    logic       opFrameError;
    logic       opBusy;

    uart_rx_byte #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .ipClk        (ipClk),
        .ipnReset     (ipnReset),
        .ipRx         (ipRx),
        .opData       (opData),
        .opValid      (opValid),
        .opFrameError (opFrameError),
        .opBusy       (opBusy)
    );

    always #50 ipClk = ~ipClk;

    int unsigned cyc = 0;
    always @(posedge ipClk) cyc <= cyc + 1;

    // Strobe monitor, sampled just after each rising edge.
    int unsigned v_cnt = 0;
    int unsigned fe_cnt = 0;
    int unsigned v_cyc = 0;
    int unsigned fe_cyc = 0;
    int unsigned overlap_cnt = 0;
    int unsigned long_cnt = 0;
    logic        prev_v = 1'b0;
    logic [7:0]  got_q[$];

    always @(posedge ipClk) begin
        #1;
        if (opValid) begin
            v_cnt++;
            v_cyc = cyc;
            got_q.push_back(opData);
        end
        if (opFrameError) begin
            fe_cnt++;
            fe_cyc = cyc;
        end
        if (opValid && opFrameError) overlap_cnt++;
        if (opValid && prev_v) long_cnt++;
        prev_v = opValid;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after rising edge number 'target'.
    task automatic wait_edge(input int unsigned target);
        while (cyc < target) begin
            @(posedge ipClk);
            #1;
        end
    endtask

    // Start, 8 data bits LSB first, one stop bit; line left at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int unsigned bit_t);
        ipRx = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            ipRx = b[i];
            #(bit_t);
        end
        ipRx = stop;
        #(bit_t);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    int unsigned e0;
    int unsigned vb;
    int unsigned fb;
    int          qb;

    initial begin
        ipnReset = 1'b0;
        ipRx     = 1'b1;
        repeat (3) @(posedge ipClk);
        #1;
        chk("rst_data", 32'(opData), 32'h00);
        chk("rst_valid", 32'(opValid), 32'd0);
        chk("rst_ferr", 32'(opFrameError), 32'd0);
        chk("rst_busy", 32'(opBusy), 32'd0);
        @(negedge ipClk);
        ipnReset = 1'b1;
        repeat (5) @(negedge ipClk);

        // 1: single 0xA5 at exact baud
        e0 = cyc + 1; vb = v_cnt; fb = fe_cnt; qb = got_q.size();
        send_frame(8'hA5, 1'b1, BIT_T);
        ipRx = 1'b1;
        #(2 * BIT_T);
        chk("a5_count", 32'(v_cnt - vb), 32'd1);
        chk("a5_edge", 32'(v_cyc - e0), 32'(STOP_EDGE));
        chk("a5_strobe_data", (got_q.size() > qb) ? 32'(got_q[qb]) : 32'hDEAD, 32'hA5);
        chk("a5_held_data", 32'(opData), 32'hA5);
        chk("a5_ferr", 32'(fe_cnt - fb), 32'd0);

        // 2: 0x00 then 0xFF back to back
        @(negedge ipClk);
        vb = v_cnt; fb = fe_cnt; qb = got_q.size();
        send_frame(8'h00, 1'b1, BIT_T);
        send_frame(8'hFF, 1'b1, BIT_T);
        ipRx = 1'b1;
        #(2 * BIT_T);
        chk("b2b_count", 32'(v_cnt - vb), 32'd2);
        chk("b2b_first", (got_q.size() > qb) ? 32'(got_q[qb]) : 32'hDEAD, 32'h00);
        chk("b2b_second", (got_q.size() > qb + 1) ? 32'(got_q[qb+1]) : 32'hDEAD, 32'hFF);

        // 3: 5-cycle glitch rejected at the start sample
        @(negedge ipClk);
        e0 = cyc + 1; vb = v_cnt; fb = fe_cnt;
        ipRx = 1'b0;
        repeat (5) @(negedge ipClk);
        ipRx = 1'b1;
        wait_edge(e0 + 5);
        chk("glitch_busy_mid", 32'(opBusy), 32'd1);
        wait_edge(e0 + 10);
        chk("glitch_busy_end", 32'(opBusy), 32'd0);
        repeat (40) @(negedge ipClk);
        chk("glitch_valid", 32'(v_cnt - vb), 32'd0);
        chk("glitch_ferr", 32'(fe_cnt - fb), 32'd0);

        // 4: 0x3C with low stop bit, then line held low
        @(negedge ipClk);
        e0 = cyc + 1; vb = v_cnt; fb = fe_cnt;
        send_frame(8'h3C, 1'b0, BIT_T);
        #(40 * BIT_T);
        chk("ferr_count", 32'(fe_cnt - fb), 32'd1);
        chk("ferr_edge", 32'(fe_cyc - e0), 32'(STOP_EDGE));
        chk("ferr_valid", 32'(v_cnt - vb), 32'd0);
        chk("ferr_data_held", 32'(opData), 32'hFF);
        chk("ferr_busy_low_line", 32'(opBusy), 32'd1);
        ipRx = 1'b1;
        repeat (5) @(negedge ipClk);
        chk("ferr_busy_released", 32'(opBusy), 32'd0);

        // 5: reset during bit 4, then 0x5A
        @(negedge ipClk);
        e0 = cyc + 1; vb = v_cnt; fb = fe_cnt;
        fork
            send_frame(8'hF0, 1'b1, BIT_T);
            begin
                wait_edge(e0 + 88);
                ipnReset = 1'b0;
                #5;
                chk("mid_rst_data", 32'(opData), 32'h00);
                chk("mid_rst_valid", 32'(opValid), 32'd0);
                chk("mid_rst_ferr", 32'(opFrameError), 32'd0);
                chk("mid_rst_busy", 32'(opBusy), 32'd0);
                #200;
                ipnReset = 1'b1;
            end
        join
        ipRx = 1'b1;
        #(2 * BIT_T);
        @(negedge ipClk);
        send_frame(8'h5A, 1'b1, BIT_T);
        ipRx = 1'b1;
        #(2 * BIT_T);
        chk("post_rst_count", 32'(v_cnt - vb), 32'd1);
        chk("post_rst_data", 32'(opData), 32'h5A);
        chk("post_rst_ferr", 32'(fe_cnt - fb), 32'd0);

        // 6: 0x81 at +3 % and -3 % baud error
        @(negedge ipClk);
        vb = v_cnt; fb = fe_cnt; qb = got_q.size();
        send_frame(8'h81, 1'b1, BIT_F);
        ipRx = 1'b1;
        #(2 * BIT_T);
        send_frame(8'h81, 1'b1, BIT_S);
        ipRx = 1'b1;
        #(2 * BIT_T);
        chk("baud_count", 32'(v_cnt - vb), 32'd2);
        chk("baud_fast", (got_q.size() > qb) ? 32'(got_q[qb]) : 32'hDEAD, 32'h81);
        chk("baud_slow", (got_q.size() > qb + 1) ? 32'(got_q[qb+1]) : 32'hDEAD, 32'h81);
        chk("baud_ferr", 32'(fe_cnt - fb), 32'd0);

        // Strobe properties over the whole run
        chk("strobe_overlap", 32'(overlap_cnt), 32'd0);
        chk("valid_width", 32'(long_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Serial receive front end for the PC link: it turns the raw `ipUART_Rx` pin into validated 8N1 bytes for the packetiser's byte input. It synchronises the asynchronous line and qualifies the start bit at mid-bit. It samples each data bit at its centre, then checks the stop bit. Each good byte is presented with a one-cycle strobe; bad framing raises an error strobe instead.

## Interface
- `CLKS_PER_BIT`, default 434: ipClk cycles per bit (50 MHz / 115200). Legal range is ≥ 4; elaboration fails below that.
- `ipClk`  in  1: system clock; all state on its rising edge.
- `ipnReset`  in  1: one clock; reset is asynchronous and active-low.
- `ipRx`  in  1: raw serial line, idle high, asynchronous to ipClk.
- `opData`  out  8: last good byte, LSB received first; holds until the next good byte.
- `opValid`  out  1: one-cycle strobe; opData is new in that cycle.
- `opFrameError`  out  1: one-cycle strobe; stop bit sampled low.
- `opBusy`  out  1: high in every state except IDLE.

## Operation
- **Synchroniser:** ipRx passes through a 2-flop synchroniser (`rx_s`); both flops reset to 1. All decisions use `rx_s` only.
- **Counters:** `bit_cnt` (clog2(CLKS_PER_BIT) bits) and `bit_idx` (3 bits).
- **Half-bit point:** H = (CLKS_PER_BIT−1)/2, integer division.
- **States:** IDLE, START, DATA, STOP, BREAK.
  - **IDLE:** when `rx_s`=0, go to START with `bit_cnt`=0.
  - **START:** count up. When `bit_cnt`=H, sample `rx_s`.
    - 0 → go to DATA with `bit_cnt`=0, `bit_idx`=0.
    - 1 → glitch; return to IDLE with no strobe.
  - **DATA:** count 0..CLKS_PER_BIT−1. At CLKS_PER_BIT−1, shift `rx_s` into shift register bit `bit_idx` (LSB first) and clear `bit_cnt`.
    - After `bit_idx`=7 is sampled, go to STOP.
  - **STOP:** count 0..CLKS_PER_BIT−1 and sample at CLKS_PER_BIT−1.
    - 1 → `opData`<=shift register, pulse `opValid`, go to IDLE.
    - 0 → pulse `opFrameError`, `opData` unchanged, go to BREAK.
  - **BREAK:** wait until `rx_s`=1, then go to IDLE. This prevents a held-low line from being read as repeated start bits.
- `opValid` and `opFrameError` are never high together.
- No receive buffering. The consumer must accept `opValid` in the strobe cycle; there is no back-pressure.
- Reset mid-frame: all state is cleared immediately and the partial byte is discarded. No strobe is emitted on reset release.

## Timing
- **Reset values:** `opData`=8'h00, `opValid`=0, `opFrameError`=0, `opBusy`=0, state=IDLE, synchroniser=2'b11.
- **Reference edge:** edge 0 is the first ipClk edge that captures ipRx low.
  - START is entered at edge 2.
  - Start sample at edge 2+H.
  - Data bit i is sampled at edge 2+H+(i+1)·CLKS_PER_BIT.
  - Stop sample at edge 2+H+9·CLKS_PER_BIT.
- **Output latency:** `opValid`/`opFrameError` are registered and high for exactly the cycle after the stop-sample edge.
- **Back-to-back frames:** IDLE is re-entered at mid-stop-bit, so a start bit immediately after a 1-bit stop is caught. Tolerated baud mismatch is about ±4 % at CLKS_PER_BIT ≥ 16.
- **opBusy:** combinational from state.

## Structure
- Add the state enum `UART_RX_STATE` {IDLE, START, DATA, STOP, BREAK} to the `Structures` package, next to `UART_PACKET`.
- Add `UART_CLKS_PER_BIT` (434) to `Structures` as the shared default, so the TX side uses the same constant.
- Sub-module `sync_2ff` (parameterised reset value) for the synchroniser. It is reused later for `ipButtons`.
- All other logic lives in a single FSM process plus an output register process.

## Test plan
Bench runs with CLKS_PER_BIT=16 (H=7); edges are counted from edge 0.

1. Send 0xA5 (8N1, exact baud) → `opValid` for 1 cycle after edge 153, `opData`=8'hA5, `opFrameError` never high.
2. Send 0x00 and 0xFF back to back with one stop bit each → two `opValid` pulses, data 00 then FF, second start detected.
3. Drive ipRx low for 5 cycles only → returns to IDLE after the start sample, no strobe, `opBusy` low again by edge 10.
4. Send 0x3C with stop bit 0, then hold line low 40 bit times → one `opFrameError` pulse, `opData` keeps its previous value, `opBusy` high until the line returns high.
5. Assert `ipnReset` during bit 4 of a frame, release, then send 0x5A → outputs at reset values immediately; only 0x5A is reported.
6. Send 0x81 at +3 % and −3 % baud error → `opData`=8'h81 both times.
